// File: rtl/exe_fwd_ctrl_pkg.sv
// Shared pipeline constants for the EXE forwarding/hazard controller:
// forward selects, writeback encodings and the load-use FSM state type.
package exe_fwd_ctrl_pkg;

  // Operand-bypass selects driven onto ForwardA/ForwardB.
  localparam logic [1:0] FWD_REG   = 2'b00;
  localparam logic [1:0] FWD_EXMEM = 2'b01;
  localparam logic [1:0] FWD_MEMWB = 2'b10;

  // MemtoReg writeback source encodings.
  localparam logic [1:0] WB_ALU = 2'b00;
  localparam logic [1:0] WB_MEM = 2'b01;
  localparam logic [1:0] WB_PC4 = 2'b10;

  typedef logic [0:0] ld_state_t;

  localparam ld_state_t ST_IDLE  = 1'b0;
  localparam ld_state_t ST_STALL = 1'b1;

  localparam int unsigned CNT_W = 32;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] val);
    return (&val) ? val : val + CNT_W'(1);
  endfunction

endpackage

// File: rtl/exe_fwd_ctrl_fwd_select.sv
// Priority bypass select for one EXE operand: EX/MEM beats MEM/WB, x0 never forwards,
// and an immediate operand always reads from the register/immediate path.
module fwd_select
  import exe_fwd_ctrl_pkg::*;
#(
  parameter int unsigned REG_AW = 5
) (
  input  logic [REG_AW-1:0] rs_i,
  input  logic              imm_i,
  input  logic              we_m_i,
  input  logic [REG_AW-1:0] rd_m_i,
  input  logic [1:0]        mtr_m_i,
  input  logic              we_w_i,
  input  logic [REG_AW-1:0] rd_w_i,
  output logic [1:0]        fwd_o
);

  logic hit_m;
  logic hit_w;

  always_comb begin
    // A load sitting in EX/MEM has no data yet; it is covered by the load-use stall.
    hit_m = we_m_i && (rd_m_i != '0) && (rd_m_i == rs_i) && (mtr_m_i != WB_MEM);
    hit_w = we_w_i && (rd_w_i != '0) && (rd_w_i == rs_i);
    fwd_o = FWD_REG;
    if (!imm_i) begin
      if (hit_m) begin
        fwd_o = FWD_EXMEM;
      end else if (hit_w) begin
        fwd_o = FWD_MEMWB;
      end
    end
  end

endmodule

// File: rtl/exe_fwd_ctrl.sv
// EXE-stage forwarding and load-use hazard controller for the 5-stage RV32 pipeline.
// Optional performance counters are enabled with `define EXE_FWD_PERF_EN.
module exe_fwd_ctrl
  import exe_fwd_ctrl_pkg::*;
#(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned REG_AW = 5
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [REG_AW-1:0] rs1_ID,
  input  logic [REG_AW-1:0] rs2_ID,
  input  logic [REG_AW-1:0] rs1_EX,
  input  logic [REG_AW-1:0] rs2_EX,
  input  logic              ALUSrc,
  input  logic [REG_AW-1:0] RegDestination,
  input  logic              RegWrite,
  input  logic              MemRead,
  input  logic [1:0]        MemtoReg,
  input  logic [XLEN-1:0]   pc,
  input  logic [XLEN-1:0]   ALUresult,
  input  logic [XLEN-1:0]   ReadData_MEM,
  input  logic              flush_EX,
  output logic [1:0]        ForwardA,
  output logic [1:0]        ForwardB,
  output logic [XLEN-1:0]   ALUresult_EXE_MEM,
  output logic [XLEN-1:0]   ALUresult_MEM_WB,
  output logic              stall_IF,
  output logic              stall_ID,
`ifdef EXE_FWD_PERF_EN
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  fwd_cnt,
`endif
  output logic              bubble_EX
);

  localparam logic [XLEN-1:0] PcStep = XLEN'(4);

  // EX/MEM shadow
  logic [REG_AW-1:0] rd_m_q, rd_m_d;
  logic              we_m_q, we_m_d;
  logic [1:0]        mtr_m_q, mtr_m_d;
  logic [XLEN-1:0]   val_m_q, val_m_d;

  // MEM/WB shadow
  logic [REG_AW-1:0] rd_w_q, rd_w_d;
  logic              we_w_q, we_w_d;
  logic [XLEN-1:0]   val_w_q, val_w_d;

  ld_state_t state_q, state_d;
  logic      hazard;
  logic      load_stall;

  always_comb begin
    rd_m_d  = RegDestination;
    we_m_d  = RegWrite & ~flush_EX;
    mtr_m_d = MemtoReg;
    // Load data is not known here; its slot is refilled from ReadData_MEM one hop later.
    val_m_d = (MemtoReg == WB_PC4) ? (pc + PcStep) : ALUresult;

    rd_w_d  = rd_m_q;
    we_w_d  = we_m_q;
    val_w_d = (mtr_m_q == WB_MEM) ? ReadData_MEM : val_m_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_m_q  <= '0;
      we_m_q  <= 1'b0;
      mtr_m_q <= '0;
      val_m_q <= '0;
      rd_w_q  <= '0;
      we_w_q  <= 1'b0;
      val_w_q <= '0;
    end else begin
      rd_m_q  <= rd_m_d;
      we_m_q  <= we_m_d;
      mtr_m_q <= mtr_m_d;
      val_m_q <= val_m_d;
      rd_w_q  <= rd_w_d;
      we_w_q  <= we_w_d;
      val_w_q <= val_w_d;
    end
  end

  fwd_select #(
    .REG_AW (REG_AW)
  ) u_fwd_a (
    .rs_i    (rs1_EX),
    .imm_i   (1'b0),
    .we_m_i  (we_m_q),
    .rd_m_i  (rd_m_q),
    .mtr_m_i (mtr_m_q),
    .we_w_i  (we_w_q),
    .rd_w_i  (rd_w_q),
    .fwd_o   (ForwardA)
  );

  fwd_select #(
    .REG_AW (REG_AW)
  ) u_fwd_b (
    .rs_i    (rs2_EX),
    .imm_i   (ALUSrc),
    .we_m_i  (we_m_q),
    .rd_m_i  (rd_m_q),
    .mtr_m_i (mtr_m_q),
    .we_w_i  (we_w_q),
    .rd_w_i  (rd_w_q),
    .fwd_o   (ForwardB)
  );

  always_comb begin
    hazard = MemRead & RegWrite & ~flush_EX & (RegDestination != '0) &
             ((RegDestination == rs1_ID) | (RegDestination == rs2_ID));
    // Gated by reset so the stall outputs read 0 while reset is held.
    load_stall = reset_n & (state_q == ST_IDLE) & hazard;
    state_d    = load_stall ? ST_STALL : ST_IDLE;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  assign stall_IF          = load_stall;
  assign stall_ID          = load_stall;
  assign bubble_EX         = load_stall;
  assign ALUresult_EXE_MEM = val_m_q;
  assign ALUresult_MEM_WB  = val_w_q;

`ifdef EXE_FWD_PERF_EN
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] fwd_cnt_q, fwd_cnt_d;

  always_comb begin
    stall_cnt_d = load_stall ? sat_inc(stall_cnt_q) : stall_cnt_q;
    fwd_cnt_d   = ((ForwardA != FWD_REG) || (ForwardB != FWD_REG)) ?
                  sat_inc(fwd_cnt_q) : fwd_cnt_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stall_cnt_q <= '0;
      fwd_cnt_q   <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      fwd_cnt_q   <= fwd_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign fwd_cnt   = fwd_cnt_q;
`endif

endmodule

// File: tb/tb_exe_fwd_ctrl.sv
// Directed-vector bench for exe_fwd_ctrl: forwarding distances, load-use stall, immediate,
// x0, flush and asynchronous reset during a stall.
module tb_exe_fwd_ctrl;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned REG_AW = 5;

  logic              clk;
  logic              reset_n;
  logic [REG_AW-1:0] rs1_ID, rs2_ID, rs1_EX, rs2_EX, RegDestination;
  logic              ALUSrc, RegWrite, MemRead, flush_EX;
  logic [1:0]        MemtoReg;
  logic [XLEN-1:0]   pc, ALUresult, ReadData_MEM;
  logic [1:0]        ForwardA, ForwardB;
  logic [XLEN-1:0]   ALUresult_EXE_MEM, ALUresult_MEM_WB;
  logic              stall_IF, stall_ID, bubble_EX;
`ifdef EXE_FWD_PERF_EN
  logic [31:0]       stall_cnt, fwd_cnt;
`endif

  int checks = 0;
  int errors = 0;

  exe_fwd_ctrl #(
    .XLEN   (XLEN),
    .REG_AW (REG_AW)
  ) dut (
    .clk               (clk),
    .reset_n           (reset_n),
    .rs1_ID            (rs1_ID),
    .rs2_ID            (rs2_ID),
    .rs1_EX            (rs1_EX),
    .rs2_EX            (rs2_EX),
    .ALUSrc            (ALUSrc),
    .RegDestination    (RegDestination),
    .RegWrite          (RegWrite),
    .MemRead           (MemRead),
    .MemtoReg          (MemtoReg),
    .pc                (pc),
    .ALUresult         (ALUresult),
    .ReadData_MEM      (ReadData_MEM),
    .flush_EX          (flush_EX),
    .ForwardA          (ForwardA),
    .ForwardB          (ForwardB),
    .ALUresult_EXE_MEM (ALUresult_EXE_MEM),
    .ALUresult_MEM_WB  (ALUresult_MEM_WB),
    .stall_IF          (stall_IF),
    .stall_ID          (stall_ID),
`ifdef EXE_FWD_PERF_EN
    .stall_cnt         (stall_cnt),
    .fwd_cnt           (fwd_cnt),
`endif
    .bubble_EX         (bubble_EX)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic nop_in();
    rs1_ID = '0; rs2_ID = '0; rs1_EX = '0; rs2_EX = '0;
    ALUSrc = 1'b0; RegDestination = '0; RegWrite = 1'b0; MemRead = 1'b0;
    MemtoReg = 2'b00; pc = '0; ALUresult = '0; ReadData_MEM = '0; flush_EX = 1'b0;
  endtask

  task automatic ex_alu(input logic [4:0] rd, input logic [4:0] s1, input logic [4:0] s2,
                        input logic [31:0] res);
    nop_in();
    RegDestination = rd; RegWrite = 1'b1; rs1_EX = s1; rs2_EX = s2; ALUresult = res;
  endtask

  task automatic ex_load(input logic [4:0] rd, input logic [31:0] addr);
    nop_in();
    RegDestination = rd; RegWrite = 1'b1; MemRead = 1'b1; MemtoReg = 2'b01;
    ALUresult = addr;
  endtask

  task automatic test_reset();
    nop_in();
    reset_n = 1'b0;
    #12;
    checks++;
    if ({ForwardA, ForwardB, stall_IF, stall_ID, bubble_EX} !== 7'b0) begin
      errors++;
      $display("FAIL reset_ctrl got %b want 0", {ForwardA, ForwardB, stall_IF, stall_ID, bubble_EX});
    end
    checks++;
    if ({ALUresult_EXE_MEM, ALUresult_MEM_WB} !== 64'h0) begin
      errors++;
      $display("FAIL reset_vals got %h %h want 0", ALUresult_EXE_MEM, ALUresult_MEM_WB);
    end
`ifdef EXE_FWD_PERF_EN
    checks++;
    if ({stall_cnt, fwd_cnt} !== 64'h0) begin
      errors++;
      $display("FAIL reset_cnt got %h %h want 0", stall_cnt, fwd_cnt);
    end
`endif
    @(negedge clk);
    reset_n = 1'b1;
    step();
  endtask

  task automatic test_alu_fwd();
    ex_alu(5'd5, 5'd1, 5'd2, 32'd70);        // add x5
    step();
    ex_alu(5'd6, 5'd5, 5'd1, 32'd69);        // sub x6,x5,x1
    #1;
    checks++;
    if (ForwardA !== 2'b01 || ForwardB !== 2'b00) begin
      errors++;
      $display("FAIL alu_fwd_sel got A=%b B=%b want A=01 B=00", ForwardA, ForwardB);
    end
    checks++;
    if (ALUresult_EXE_MEM !== 32'd70) begin
      errors++;
      $display("FAIL alu_fwd_val got %0d want 70", ALUresult_EXE_MEM);
    end
    step();
    nop_in();
    step();
    step();
  endtask

  task automatic test_two_dist();
    ex_alu(5'd5, 5'd1, 5'd2, 32'd11);        // add x5
    step();
    nop_in();
    step();
    ex_alu(5'd7, 5'd5, 5'd5, 32'd0);         // or x7,x5,x5
    #1;
    checks++;
    if (ForwardA !== 2'b10 || ForwardB !== 2'b10 || ALUresult_MEM_WB !== 32'd11) begin
      errors++;
      $display("FAIL two_dist got A=%b B=%b v=%0d want A=10 B=10 v=11",
               ForwardA, ForwardB, ALUresult_MEM_WB);
    end
    ex_alu(5'd5, 5'd1, 5'd2, 32'd11);
    step();
    ex_alu(5'd5, 5'd3, 5'd4, 32'd22);        // newer write to x5
    step();
    ex_alu(5'd7, 5'd5, 5'd5, 32'd0);
    #1;
    checks++;
    if (ForwardA !== 2'b01 || ForwardB !== 2'b01) begin
      errors++;
      $display("FAIL newer_wins got A=%b B=%b want 01 01", ForwardA, ForwardB);
    end
    checks++;
    if (ALUresult_EXE_MEM !== 32'd22 || ALUresult_MEM_WB !== 32'd11) begin
      errors++;
      $display("FAIL newer_vals got %0d %0d want 22 11", ALUresult_EXE_MEM, ALUresult_MEM_WB);
    end
    nop_in();
    RegDestination = 5'd1; RegWrite = 1'b1; MemtoReg = 2'b10; pc = 32'h100;  // jal x1
    step();
    nop_in();
    #1;
    checks++;
    if (ALUresult_EXE_MEM !== 32'h104) begin
      errors++;
      $display("FAIL pc4_val got %h want 00000104", ALUresult_EXE_MEM);
    end
    step();
    step();
  endtask

  task automatic test_load_use();
    ex_load(5'd3, 32'h40);                   // lw x3
    rs1_ID = 5'd3; rs2_ID = 5'd2;            // add x4,x3,x2 in ID
    #1;
    checks++;
    if ({stall_IF, stall_ID, bubble_EX} !== 3'b111) begin
      errors++;
      $display("FAIL lu_stall got %b want 111", {stall_IF, stall_ID, bubble_EX});
    end
    step();
    nop_in();                                // bubble in EX, add held in ID
    rs1_ID = 5'd3; rs2_ID = 5'd2;
    ReadData_MEM = 32'hDEAD_BEEF;
    #1;
    checks++;
    if ({stall_IF, stall_ID, bubble_EX} !== 3'b000) begin
      errors++;
      $display("FAIL lu_one_cycle got %b want 000", {stall_IF, stall_ID, bubble_EX});
    end
    step();
    ex_alu(5'd4, 5'd3, 5'd2, 32'd0);
    #1;
    checks++;
    if (ForwardA !== 2'b10 || ForwardB !== 2'b00 || ALUresult_MEM_WB !== 32'hDEAD_BEEF) begin
      errors++;
      $display("FAIL lu_fwd got A=%b B=%b v=%h want A=10 B=00 v=deadbeef",
               ForwardA, ForwardB, ALUresult_MEM_WB);
    end
    step();
    nop_in();
    step();
    step();
  endtask

  task automatic test_imm_x0();
    ex_alu(5'd5, 5'd1, 5'd2, 32'd5);
    step();
    ex_alu(5'd8, 5'd0, 5'd5, 32'd0);         // addi with rs2 field = 5
    ALUSrc = 1'b1;
    #1;
    checks++;
    if (ForwardB !== 2'b00 || ForwardA !== 2'b00) begin
      errors++;
      $display("FAIL imm_b got A=%b B=%b want 00 00", ForwardA, ForwardB);
    end
    ALUSrc = 1'b0;
    #1;
    checks++;
    if (ForwardB !== 2'b01) begin
      errors++;
      $display("FAIL reg_b got B=%b want 01", ForwardB);
    end
    step();
    nop_in();
    step();
    step();
    ex_load(5'd0, 32'h80);                   // lw x0
    rs1_ID = 5'd0; rs2_ID = 5'd0;
    #1;
    checks++;
    if (stall_IF !== 1'b0 || bubble_EX !== 1'b0) begin
      errors++;
      $display("FAIL x0_stall got %b%b want 00", stall_IF, bubble_EX);
    end
    step();
    ex_alu(5'd0, 5'd1, 5'd2, 32'd99);        // write x0
    step();
    ex_alu(5'd9, 5'd0, 5'd0, 32'd0);
    #1;
    checks++;
    if (ForwardA !== 2'b00 || ForwardB !== 2'b00) begin
      errors++;
      $display("FAIL x0_fwd got A=%b B=%b want 00 00", ForwardA, ForwardB);
    end
    step();
    nop_in();
    step();
    step();
  endtask

  task automatic test_flush();
    ex_load(5'd3, 32'h40);
    flush_EX = 1'b1;
    rs1_ID = 5'd3;
    #1;
    checks++;
    if ({stall_IF, stall_ID, bubble_EX} !== 3'b000) begin
      errors++;
      $display("FAIL flush_stall got %b want 000", {stall_IF, stall_ID, bubble_EX});
    end
    step();
    step();                                  // killed load now in MEM/WB slot
    ex_alu(5'd4, 5'd3, 5'd3, 32'd0);
    #1;
    checks++;
    if (ForwardA !== 2'b00 || ForwardB !== 2'b00) begin
      errors++;
      $display("FAIL flush_fwd got A=%b B=%b want 00 00", ForwardA, ForwardB);
    end
    nop_in();
    step();
    step();
  endtask

  task automatic test_reset_mid_stall();
    ex_alu(5'd5, 5'd1, 5'd2, 32'd7);
    step();
    ex_load(5'd3, 32'h40);
    rs1_ID = 5'd3;
    step();                                  // now in STALL
    rs1_EX = 5'd5;                           // hazard inputs still present
    #1;
    checks++;
    if (stall_IF !== 1'b0 || ForwardA !== 2'b10 || ALUresult_MEM_WB !== 32'd7) begin
      errors++;
      $display("FAIL in_stall got s=%b A=%b v=%0d want s=0 A=10 v=7",
               stall_IF, ForwardA, ALUresult_MEM_WB);
    end
    reset_n = 1'b0;
    #1;
    checks++;
    if ({ForwardA, ForwardB, stall_IF, stall_ID, bubble_EX} !== 7'b0 ||
        {ALUresult_EXE_MEM, ALUresult_MEM_WB} !== 64'h0) begin
      errors++;
      $display("FAIL rst_mid got %b %h %h want 0", {ForwardA, ForwardB, stall_IF, stall_ID,
               bubble_EX}, ALUresult_EXE_MEM, ALUresult_MEM_WB);
    end
    step();
    reset_n = 1'b1;
    nop_in();
    rs1_EX = 5'd5;
    #1;
    checks++;
    if (ForwardA !== 2'b00) begin
      errors++;
      $display("FAIL rst_stale got A=%b want 00", ForwardA);
    end
    ex_load(5'd3, 32'h40);
    rs1_ID = 5'd3;
    #1;
    checks++;
    if (stall_IF !== 1'b1) begin
      errors++;
      $display("FAIL rst_idle got stall=%b want 1", stall_IF);
    end
    step();
    nop_in();
    step();
  endtask

  initial begin
    nop_in();
    test_reset();
    test_alu_fwd();
    test_two_dist();
    test_load_use();
    test_imm_x0();
    test_flush();
    test_reset_mid_stall();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/exe_fwd_ctrl.md
# exe_fwd_ctrl

Forwarding and hazard controller that drives the EXE stage's operand-bypass inputs (`ForwardA`, `ForwardB`, `ALUresult_EXE_MEM`, `ALUresult_MEM_WB`).

- Keeps a shadow copy of destination/control state for the EX/MEM and MEM/WB hops.
- Registers the forwarded result values.
- Detects load-use hazards and generates stall/bubble controls for IF, ID and the ID/EX boundary.
- Sits beside the EXE stage in the 5-stage RV32 pipeline.

## Interface
Parameters:
- `XLEN`, 32, datapath width
- `REG_AW`, 5, register-index width

Ports:
- `clk`  in  1  pipeline clock; all registers are rising-edge
- `reset_n`  in  1  asynchronous active-low reset
- `rs1_ID`, `rs2_ID`  in  REG_AW  source indices of the instruction in ID
- `rs1_EX`, `rs2_EX`  in  REG_AW  source indices of the instruction in EX
- `ALUSrc`  in  1  EX instruction uses the immediate as operand B
- `RegDestination`  in  REG_AW  EX destination register
- `RegWrite`, `MemRead`  in  1  EX control bits
- `MemtoReg`  in  2  EX writeback select: 00 = ALU, 01 = memory, 10 = pc+4
- `pc`  in  XLEN  EX instruction PC
- `ALUresult`  in  XLEN  EXE stage ALU output
- `ReadData_MEM`  in  XLEN  load data returned in the MEM stage
- `flush_EX`  in  1  kill the instruction currently in EX (branch redirect)
- `ForwardA`, `ForwardB`  out  2  operand select: 00 = register, 01 = EX/MEM, 10 = MEM/WB; 11 is never driven
- `ALUresult_EXE_MEM`, `ALUresult_MEM_WB`  out  XLEN  forwarded values
- `stall_IF`, `stall_ID`  out  1  hold PC and the IF/ID register
- `bubble_EX`  out  1  zero control bits entering ID/EX

## Operation
EX/MEM shadow register, captured every cycle:
- Fields: `rd_m`, `we_m`, `mtr_m`, `val_m`.
- `we_m = RegWrite & ~flush_EX`.
- `val_m = ALUresult` when MemtoReg is 00, `pc+4` when 10, and don't-care when 01.

MEM/WB shadow register, captured every cycle:
- Fields: `rd_w`, `we_w`, `val_w`.
- `val_w = ReadData_MEM` when `mtr_m` is 01, otherwise `val_m`.

Output mapping:
- `ALUresult_EXE_MEM = val_m`
- `ALUresult_MEM_WB = val_w`

ForwardA:
- 01 if `we_m & rd_m!=0 & rd_m==rs1_EX & mtr_m!=01`.
- Otherwise 10 if `we_w & rd_w!=0 & rd_w==rs1_EX`.
- Otherwise 00.
- EX/MEM has priority over MEM/WB.

ForwardB:
- Same rule using `rs2_EX`.
- Forced to 00 when `ALUSrc=1`, because the immediate must never be overridden.

Load-use FSM, states IDLE and STALL:
- IDLE: a hazard exists when `MemRead & RegWrite & ~flush_EX & RegDestination!=0 & (RegDestination==rs1_ID | RegDestination==rs2_ID)`.
  - On a hazard: assert `stall_IF`, `stall_ID` and `bubble_EX` combinationally, and go to STALL.
- STALL: all three outputs are deasserted and the state returns to IDLE unconditionally. The bubble in EX guarantees no repeat hazard from the same load.
  - In STALL, the stalled instruction in ID now sees the load in MEM and obtains its data via MEM/WB forwarding on the next cycle.
- `flush_EX` in IDLE suppresses the hazard: a killed load causes no stall.

## Timing
- ForwardA/B, stall and bubble outputs are combinational from registered state plus current inputs, with no cycle of latency.
- Forwarded values lag their producer by exactly 1 cycle (EX/MEM) or 2 cycles (MEM/WB).
- A load-use pair costs exactly one stall cycle.
- Reset (asynchronous, any cycle, including mid-stall):
  - All shadow registers clear to 0 (`we_m = we_w = 0`).
  - FSM goes to IDLE.
  - All outputs read 0.
- Register x0 is never forwarded, even if a write to it is in flight.
- When a MEM/WB destination equals an EX/MEM destination, the EX/MEM (newer) value wins.

## Configuration
`EXE_FWD_PERF_EN`:
- Defined: adds outputs `stall_cnt` and `fwd_cnt` (32 bits each, saturating at all-ones, cleared by reset).
  - `stall_cnt` increments once per stall cycle.
  - `fwd_cnt` increments once per cycle in which ForwardA or ForwardB is nonzero.
- Undefined: the ports and counters do not exist, and behaviour is otherwise identical.

## Structure
- Shared pipeline package holds:
  - Forward-select constants: `FWD_REG`, `FWD_EXMEM`, `FWD_MEMWB`.
  - MemtoReg encodings: `WB_ALU`, `WB_MEM`, `WB_PC4`.
  - FSM state type.
- One sub-module, `fwd_select`: purely combinational priority compare for one operand, instantiated twice.

## Test plan
- ALU result forward: `add x5` then `sub x6,x5,x1` → ForwardA=01 in the sub's EX cycle, and `ALUresult_EXE_MEM` equals the add result (e.g. 70).
- Two-distance forward: `add x5`, nop, `or x7,x5,x5` → ForwardA=ForwardB=10; a same-rd write in EX/MEM at the same time yields 01.
- Load-use: `lw x3`, `add x4,x3,x2` → one cycle with `stall_IF=stall_ID=bubble_EX=1`, then ForwardA=10 with `ALUresult_MEM_WB` equal to the loaded value.
- Immediate operand and x0:
  - With ALUSrc=1 and `rs2_EX` matching `rd_m` → ForwardB=00.
  - With `rd=0` and RegWrite=1 → no forward and no stall.
- Flush: `flush_EX` asserted on a load whose destination matches `rs1_ID` → no stall, and `we_m=0` the next cycle.
- Reset: deassert `reset_n` during STALL → all outputs 0 immediately; after release the FSM is IDLE with no stale forward.
